// File: rtl/hazard3_apb_pkg.sv
// Shared APB definitions for the hazard3 requester and its completers.
// Holds the bus widths and the requester state encoding.
package hazard3_apb_pkg;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2,
        APB_RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/hazard3_apb_requester.sv
// Single-outstanding APB3 requester: valid/ready command in, APB SETUP/ACCESS out,
// registered response with slave-error and timeout status.
//
// state      | meaning
// APB_IDLE   | req_ready high, waiting for a command
// APB_SETUP  | psel high, penable low, one cycle
// APB_ACCESS | psel and penable high until pready or timeout
// APB_RESP   | resp_valid high, fields held until resp_ready
module hazard3_apb_requester
    import hazard3_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [APB_ADDR_W-1:0] req_addr,
    input  logic                  req_write,
    input  logic [APB_DATA_W-1:0] req_wdata,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [APB_DATA_W-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  resp_timeout,

    output logic [APB_ADDR_W-1:0] paddr,
    output logic                  pwrite,
    output logic [APB_DATA_W-1:0] pwdata,
    output logic                  psel,
    output logic                  penable,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    apb_state_t       state_q;
    apb_state_t       state_d;
    logic [CNT_W-1:0] tmo_cnt;
    logic             timed_out;
    logic             accept;

    assign req_ready = (state_q == APB_IDLE);
    assign accept    = req_ready && req_valid;
    // pready has priority: timeout only fires on a cycle where the completer is still stalling
    assign timed_out = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_LAST) && !pready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            APB_IDLE:   if (req_valid) state_d = APB_SETUP;
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: if (pready || timed_out) state_d = APB_RESP;
            APB_RESP:   if (resp_ready) state_d = APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= APB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus strobes are registered from the next state so no output depends on APB inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel         <= 1'b0;
            penable      <= 1'b0;
            resp_valid   <= 1'b0;
            paddr        <= '0;
            pwrite       <= 1'b0;
            pwdata       <= '0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            psel       <= (state_d == APB_SETUP) || (state_d == APB_ACCESS);
            penable    <= (state_d == APB_ACCESS);
            resp_valid <= (state_d == APB_RESP);

            if (accept) begin
                paddr   <= req_addr;
                pwrite  <= req_write;
                pwdata  <= req_wdata;
                tmo_cnt <= '0;
            end

            if (state_q == APB_ACCESS) begin
                if (pready) begin
                    resp_rdata   <= pwrite ? '0 : prdata;
                    resp_err     <= pslverr;
                    resp_timeout <= 1'b0;
                end else if (timed_out) begin
                    resp_rdata   <= '0;
                    resp_err     <= 1'b1;
                    resp_timeout <= 1'b1;
                end

                if (!pready && (tmo_cnt != '1)) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule
